// File: rtl/gpio_seg_display_pkg.sv
// Shared types and constants for the GPIO 7-segment display driver:
// converter states, active-low segment patterns, digit enables, BCD helpers.
package gpio_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [2:0] AN_ONES = 3'b110;
  localparam logic [2:0] AN_TENS = 3'b101;
  localparam logic [2:0] AN_HUND = 3'b011;
  localparam logic [2:0] AN_OFF  = 3'b111;

  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Double-dabble correction so the following shift carries into the next decade
  function automatic logic [3:0] add3(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_seg_display_seg7_decoder.sv
// Nibble to active-low 7-segment pattern; the blank flag or a non-decimal code
// turns every segment off.
module seg7_decoder
  import gpio_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup with blanking override
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = seg_pattern(nibble);
    end
  end

endmodule

// File: rtl/gpio_seg_display.sv
// GPIO value to 3-digit common-anode display: sequential double-dabble converter
// plus a free-running digit scanner with leading-zero blanking.
module gpio_seg_display
  import gpio_disp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] port_in,
  output logic [6:0]            seg,
  output logic [2:0]            an,
  output logic                  busy,
  output logic                  bcd_valid
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  conv_state_t              state_r;
  logic [DATA_WIDTH-1:0]    cap_val_r;
  logic [DATA_WIDTH-1:0]    sreg_r;
  logic [11:0]              bcd_r;
  logic [2:0]               iter_r;
  logic [3:0]               dig_h_r;
  logic [3:0]               dig_t_r;
  logic [3:0]               dig_o_r;
  logic                     busy_r;
  logic                     bcd_valid_r;
  logic [11:0]              bcd_adj_s;
  logic [11+DATA_WIDTH:0]   shift_s;

  logic [CNT_W-1:0]         refresh_cnt_r;
  logic [1:0]               digit_idx_r;
  logic [3:0]               nib_sel_s;
  logic                     blank_sel_s;
  logic [2:0]               an_sel_s;
  logic [6:0]               dec_seg_s;
  logic [6:0]               seg_r;
  logic [2:0]               an_r;

  // Correct every decade, then shift the whole {bcd, sreg} chain left by one
  always_comb begin
    bcd_adj_s = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
    shift_s   = {bcd_adj_s, sreg_r} << 1'b1;
  end

  // Converter FSM: capture on change, 8 shift iterations, publish digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cap_val_r   <= '0;
      sreg_r      <= '0;
      bcd_r       <= 12'h000;
      iter_r      <= 3'd0;
      dig_h_r     <= 4'd0;
      dig_t_r     <= 4'd0;
      dig_o_r     <= 4'd0;
      busy_r      <= 1'b0;
      bcd_valid_r <= 1'b0;
    end else begin
      bcd_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (port_in != cap_val_r) begin
            cap_val_r <= port_in;
            sreg_r    <= port_in;
            bcd_r     <= 12'h000;
            iter_r    <= 3'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_SHIFT;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          bcd_r  <= shift_s[11+DATA_WIDTH:DATA_WIDTH];
          sreg_r <= shift_s[DATA_WIDTH-1:0];
          iter_r <= iter_r + 3'd1;
          if (iter_r == 3'd7) begin
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          dig_h_r     <= bcd_r[11:8];
          dig_t_r     <= bcd_r[7:4];
          dig_o_r     <= bcd_r[3:0];
          bcd_valid_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Refresh counter and digit index, independent of the converter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= 2'd0;
    end else begin
      if (refresh_cnt_r == CNT_LAST) begin
        refresh_cnt_r <= '0;
        if (digit_idx_r == 2'd2) begin
          digit_idx_r <= 2'd0;
        end else begin
          digit_idx_r <= digit_idx_r + 2'd1;
        end
      end else begin
        refresh_cnt_r <= refresh_cnt_r + 1'b1;
      end
    end
  end

  // Select digit, enable and blanking for the current slot
  always_comb begin
    nib_sel_s   = 4'd0;
    blank_sel_s = 1'b1;
    an_sel_s    = AN_OFF;
    case (digit_idx_r)
      2'd0: begin
        nib_sel_s   = dig_o_r;
        blank_sel_s = 1'b0;
        an_sel_s    = AN_ONES;
      end
      2'd1: begin
        nib_sel_s   = dig_t_r;
        blank_sel_s = (dig_h_r == 4'd0) && (dig_t_r == 4'd0);
        an_sel_s    = AN_TENS;
      end
      2'd2: begin
        nib_sel_s   = dig_h_r;
        blank_sel_s = (dig_h_r == 4'd0);
        an_sel_s    = AN_HUND;
      end
      default: begin
        nib_sel_s   = 4'd0;
        blank_sel_s = 1'b1;
        an_sel_s    = AN_OFF;
      end
    endcase
  end

  seg7_decoder u_dec (
    .nibble (nib_sel_s),
    .blank  (blank_sel_s),
    .seg    (dec_seg_s)
  );

  // Output registers, one cycle behind the digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_r <= SEG_BLANK;
      an_r  <= AN_OFF;
    end else begin
      seg_r <= dec_seg_s;
      an_r  <= an_sel_s;
    end
  end

  assign seg       = seg_r;
  assign an        = an_r;
  assign busy      = busy_r;
  assign bcd_valid = bcd_valid_r;

endmodule

// File: tb/tb_gpio_seg_display.sv
// Directed bench for gpio_seg_display with a 4-cycle refresh slot.
module tb_gpio_seg_display;

  localparam logic [6:0] P_BLK = 7'h7F;
  localparam logic [6:0] P0 = 7'h40;
  localparam logic [6:0] P1 = 7'h79;
  localparam logic [6:0] P2 = 7'h24;
  localparam logic [6:0] P5 = 7'h12;
  localparam logic [6:0] P7 = 7'h78;

  logic       clk;
  logic       rst;
  logic [7:0] port_in;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;
  logic       bcd_valid;

  int checks;
  int errors;

  gpio_seg_display #(.DATA_WIDTH(8), .REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .port_in   (port_in),
    .seg       (seg),
    .an        (an),
    .busy      (busy),
    .bcd_valid (bcd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [2:0] a, input logic [6:0] h,
                                         input logic [6:0] t, input logic [6:0] o);
    case (a)
      3'b110:  return o;
      3'b101:  return t;
      3'b011:  return h;
      default: return P_BLK;
    endcase
  endfunction

  task automatic capture(output logic [6:0] so, output logic [6:0] st, output logic [6:0] sh);
    so = 7'bx; st = 7'bx; sh = 7'bx;
    for (int i = 0; i < 13; i++) begin
      tick();
      case (an)
        3'b110:  so = seg;
        3'b101:  st = seg;
        3'b011:  sh = seg;
        default: ;
      endcase
    end
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (bcd_valid) ok = 1'b1;
    end
    check(tag, {11'd0, ok}, 12'd1);
  endtask

  initial begin
    logic [6:0] so, st, sh;
    logic [2:0] exp_an;
    int busy_cnt, valid_cnt, busy_any;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    port_in = 8'h00;

    // Reset state with the clock running
    repeat (3) tick();
    check("rst_seg", {5'd0, seg}, {5'd0, P_BLK});
    check("rst_an", {9'd0, an}, 12'b111);
    check("rst_busy", {11'd0, busy}, 12'd0);
    check("rst_valid", {11'd0, bcd_valid}, 12'd0);

    // Scan order after release: each enable held 4 cycles, value 0 shown
    rst = 1'b1;
    busy_any = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      case (((k - 1) / 4) % 3)
        0:       exp_an = 3'b110;
        1:       exp_an = 3'b101;
        default: exp_an = 3'b011;
      endcase
      check("scan_an", {9'd0, an}, {9'd0, exp_an});
      check("scan_seg", {5'd0, seg}, {5'd0, (exp_an == 3'b110) ? P0 : P_BLK});
      if (busy) busy_any++;
    end
    check("no_busy_after_rst", 12'(busy_any), 12'd0);

    // 0 -> FF: busy 8 cycles, one valid pulse on the 10th sample
    port_in = 8'hFF;
    busy_cnt = 0;
    valid_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) check("ff_busy_rise", {11'd0, busy}, 12'd1);
      if (k == 10) check("ff_valid_at_e9", {11'd0, bcd_valid}, 12'd1);
      if (busy) busy_cnt++;
      if (bcd_valid) valid_cnt++;
    end
    check("ff_busy_cycles", 12'(busy_cnt), 12'd8);
    check("ff_valid_pulses", 12'(valid_cnt), 12'd1);
    capture(so, st, sh);
    check("ff_ones", {5'd0, so}, {5'd0, P5});
    check("ff_tens", {5'd0, st}, {5'd0, P5});
    check("ff_hund", {5'd0, sh}, {5'd0, P2});

    // 07: leading zeros blanked
    port_in = 8'h07;
    wait_valid("to_07");
    capture(so, st, sh);
    check("07_ones", {5'd0, so}, {5'd0, P7});
    check("07_tens", {5'd0, st}, {5'd0, P_BLK});
    check("07_hund", {5'd0, sh}, {5'd0, P_BLK});

    // 0A then 64 mid-shift: 10 shown first, then 100; two pulses
    port_in = 8'h0A;
    valid_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 2) port_in = 8'h64;
      if (bcd_valid) valid_cnt++;
      if (k == 10) check("chg_first_valid", {11'd0, bcd_valid}, 12'd1);
      if (k >= 11 && k <= 20)
        check("chg_shows_10", {5'd0, seg}, {5'd0, exp_seg(an, P_BLK, P1, P0)});
    end
    check("chg_valid_pulses", 12'(valid_cnt), 12'd2);
    capture(so, st, sh);
    check("100_ones", {5'd0, so}, {5'd0, P0});
    check("100_tens", {5'd0, st}, {5'd0, P0});
    check("100_hund", {5'd0, sh}, {5'd0, P1});

    // Reset at iteration 4 of C8 conversion
    port_in = 8'hC8;
    repeat (5) tick();
    check("c8_busy_before_rst", {11'd0, busy}, 12'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_seg", {5'd0, seg}, {5'd0, P_BLK});
    check("mid_rst_an", {9'd0, an}, 12'b111);
    check("mid_rst_busy", {11'd0, busy}, 12'd0);
    check("mid_rst_valid", {11'd0, bcd_valid}, 12'd0);
    check("mid_rst_cap", {4'd0, dut.cap_val_r}, 12'd0);
    repeat (2) tick();
    rst = 1'b1;
    wait_valid("to_c8");
    capture(so, st, sh);
    check("200_ones", {5'd0, so}, {5'd0, P0});
    check("200_tens", {5'd0, st}, {5'd0, P0});
    check("200_hund", {5'd0, sh}, {5'd0, P2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
